rnn_readout: RTL and testbench

RNN_READOUT -- requirements
Module: rnn_readout

---
 rtl/rnn_readout.sv | 225 ++++++++++++++++++++++
 tb/tb_rnn_readout.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_readout.sv
// rnn_readout: linear readout layer for an RNN.
//
// On start, loads 64 readout weights and a bias from memory once. Then, for
// each timestep t = 0..t_last, it streams the 64-entry hidden state h[t][k]
// from memory and accumulates sum_k h[t][k]*W[k] in a 46-bit accumulator. The
// result is rounded (half up) from Q.32 to Q4.16 and saturated. The bias is
// then added with a second saturation, and the result is presented on a
// valid/ready output.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, t_last   run request and index of the last timestep (idle only)
//   busy            high while a run is in progress
//   mce/maddr/msel  registered memory read request (msel 110 = W/bias, 101 = h)
//   mdata_r         read data, valid the cycle after a request is presented
//   o_valid/o_ready output handshake, y_out = signed Q4.16 result
//   done            one-cycle pulse after the final result is accepted
module rnn_readout (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] t_last,
    output logic        busy,
    output logic        mce,
    output logic [16:0] maddr,
    output logic [2:0]  msel,
    input  logic [19:0] mdata_r,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [19:0] y_out,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LDW, S_LDW_DRN, S_RDH, S_ACC, S_RND, S_OUT
    } state_t;

    localparam logic [2:0] SEL_H = 3'b101;
    localparam logic [2:0] SEL_W = 3'b110;

    state_t state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [10:0] t_cnt_q, t_cnt_d;
    logic [10:0] t_last_q, t_last_d;
    logic        busy_q, busy_d, mce_q, mce_d, o_valid_q, o_valid_d, done_q, done_d;
    logic [16:0] maddr_q, maddr_d;
    logic [2:0]  msel_q, msel_d;
    logic [19:0] y_q, y_d;

    // Read-return tracking: what the data arriving this cycle belongs to.
    logic        ld_vld_q, ld_vld_d, acc_vld_q, acc_vld_d;
    logic [6:0]  ld_idx_q, ld_idx_d;
    logic [5:0]  acc_k_q, acc_k_d;

    logic signed [45:0] acc_q, acc_d;
    logic signed [19:0] bias_q, bias_d;
    logic [19:0]        w_q [64];
    logic               w_we;

    // Control: next state, counters, and registered memory/handshake outputs.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        t_cnt_d  = t_cnt_q;
        t_last_d = t_last_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_LDW;
                t_last_d = t_last;
                t_cnt_d  = '0;
                k_d      = '0;
            end
            S_LDW: if (k_q == 7'd64) begin
                state_d = S_LDW_DRN;
                k_d     = '0;
            end else begin
                k_d = k_q + 7'd1;
            end
            S_LDW_DRN: state_d = S_RDH;
            S_RDH: if (k_q == 7'd63) begin
                state_d = S_ACC;
                k_d     = '0;
            end else begin
                k_d = k_q + 7'd1;
            end
            S_ACC: state_d = S_RND;
            S_RND: state_d = S_OUT;
            S_OUT: if (o_ready) begin
                if (t_cnt_q == t_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RDH;
                    t_cnt_d = t_cnt_q + 11'd1;
                    k_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d != S_IDLE);
        o_valid_d = (state_d == S_OUT);
        mce_d     = 1'b0;
        msel_d    = 3'b000;
        maddr_d   = '0;
        if (state_d == S_LDW) begin
            mce_d   = 1'b1;
            msel_d  = SEL_W;
            maddr_d = {10'd0, k_d};
        end else if (state_d == S_RDH) begin
            mce_d   = 1'b1;
            msel_d  = SEL_H;
            maddr_d = {t_cnt_d, k_d[5:0]};
        end
    end

    // Datapath: capture returning reads, multiply-accumulate, round/saturate.
    logic signed [19:0] w_sel;
    logic signed [39:0] prod;
    logic signed [45:0] acc_rnd;
    logic signed [29:0] r_full;
    logic signed [19:0] r_sat;
    logic signed [20:0] y_sum;
    logic signed [19:0] y_sat;

    always_comb begin
        ld_vld_d  = (state_q == S_LDW);
        ld_idx_d  = k_q;
        acc_vld_d = (state_q == S_RDH);
        acc_k_d   = k_q[5:0];

        // Index 64 of the load phase is the bias; 0..63 are weights.
        w_we   = ld_vld_q && !ld_idx_q[6];
        bias_d = (ld_vld_q && ld_idx_q[6]) ? mdata_r : bias_q;

        w_sel = w_q[acc_k_q];
        prod  = $signed(mdata_r) * w_sel;
        acc_d = acc_q;
        if (state_d == S_RDH && state_q != S_RDH) begin
            acc_d = '0;
        end else if (acc_vld_q) begin
            acc_d = acc_q + {{6{prod[39]}}, prod};
        end

        acc_rnd = acc_q + 46'sd32768;
        r_full  = acc_rnd[45:16];
        if (r_full > 30'sd524287) begin
            r_sat = 20'sh7FFFF;
        end else if (r_full < -30'sd524288) begin
            r_sat = 20'sh80000;
        end else begin
            r_sat = r_full[19:0];
        end

        y_sum = {r_sat[19], r_sat} + {bias_q[19], bias_q};
        if (y_sum[20] != y_sum[19]) begin
            y_sat = y_sum[20] ? 20'sh80000 : 20'sh7FFFF;
        end else begin
            y_sat = y_sum[19:0];
        end
        y_d = (state_q == S_RND) ? y_sat : y_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            t_cnt_q   <= '0;
            t_last_q  <= '0;
            busy_q    <= 1'b0;
            mce_q     <= 1'b0;
            maddr_q   <= '0;
            msel_q    <= '0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
            y_q       <= '0;
            ld_vld_q  <= 1'b0;
            ld_idx_q  <= '0;
            acc_vld_q <= 1'b0;
            acc_k_q   <= '0;
            acc_q     <= '0;
            bias_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            t_cnt_q   <= t_cnt_d;
            t_last_q  <= t_last_d;
            busy_q    <= busy_d;
            mce_q     <= mce_d;
            maddr_q   <= maddr_d;
            msel_q    <= msel_d;
            o_valid_q <= o_valid_d;
            done_q    <= done_d;
            y_q       <= y_d;
            ld_vld_q  <= ld_vld_d;
            ld_idx_q  <= ld_idx_d;
            acc_vld_q <= acc_vld_d;
            acc_k_q   <= acc_k_d;
            acc_q     <= acc_d;
            bias_q    <= bias_d;
        end
    end

    // NOTE: the weight file is flop-based and cleared by reset, so it cannot map to a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) w_q[i] <= '0;
        end else if (w_we) begin
            w_q[ld_idx_q[5:0]] <= mdata_r;
        end
    end

    assign busy    = busy_q;
    assign mce     = mce_q;
    assign maddr   = maddr_q;
    assign msel    = msel_q;
    assign o_valid = o_valid_q;
    assign y_out   = y_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rnn_readout.sv
// Self-checking bench for rnn_readout: a behavioural memory model answers
// reads one cycle later, a vector table covers single-timestep arithmetic,
// and hand-written sequences cover output stall and mid-run reset.
module tb_rnn_readout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] t_last = '0;
    logic        busy, mce, o_valid, done;
    logic [16:0] maddr;
    logic [2:0]  msel;
    logic [19:0] mdata_r = '0;
    logic        o_ready = 1'b0;
    logic [19:0] y_out;

    int n_checks = 0;
    int n_err    = 0;

    rnn_readout dut (
        .clk(clk), .reset(reset), .start(start), .t_last(t_last),
        .busy(busy), .mce(mce), .maddr(maddr), .msel(msel),
        .mdata_r(mdata_r), .o_valid(o_valid), .o_ready(o_ready),
        .y_out(y_out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [19:0] wmem [64];
    logic [19:0] hmem [4][64];
    logic [19:0] bias_m;
    logic        rd_v = 1'b0;
    logic [2:0]  rd_s = '0;
    logic [16:0] rd_a = '0;
    logic [5:0]  k_exp = '0;
    logic [10:0] t_exp = '0;
    int          addr_err = 0;
    int          overlap  = 0;

    function automatic logic [19:0] mem_rd(input logic [2:0] s, input logic [16:0] a);
        if (s == 3'b110) begin
            if (a < 17'd64) return wmem[a[5:0]];
            if (a == 17'd64) return bias_m;
        end else if (s == 3'b101) begin
            if (a[16:6] < 11'd4) return hmem[a[7:6]][a[5:0]];
        end
        return 20'hABCDE;
    endfunction

    // Sample the request mid-cycle; also verify the {t,k} hidden-state sweep.
    always @(negedge clk) begin
        rd_v = mce;
        rd_s = msel;
        rd_a = maddr;
        if (o_valid && done) overlap++;
        if (mce && msel == 3'b110 && maddr == 17'd0) begin
            k_exp = '0;
            t_exp = '0;
        end else if (mce && msel == 3'b101) begin
            if (maddr != {t_exp, k_exp}) addr_err++;
            if (k_exp == 6'd63) t_exp = t_exp + 11'd1;
            k_exp = k_exp + 6'd1;
        end
    end

    always @(posedge clk) begin
        #1;
        mdata_r = rd_v ? mem_rd(rd_s, rd_a) : 20'hABCDE;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [19:0] w_all;
        int          w_ix;
        logic [19:0] w_ixv;
        logic [19:0] h_all;
        int          h_ix;
        logic [19:0] h_ixv;
        logic [19:0] bias;
        logic [19:0] exp_y;
    } vec_t;

    vec_t vecs [8];

    task automatic set_mem(input vec_t v);
        for (int k = 0; k < 64; k++) begin
            wmem[k] = (k == v.w_ix) ? v.w_ixv : v.w_all;
            for (int t = 0; t < 4; t++) hmem[t][k] = (k == v.h_ix) ? v.h_ixv : v.h_all;
        end
        bias_m = v.bias;
    endtask

    // Stall-test memory: W=1/16, h[t][k]=(t+1)/16 so each timestep differs.
    task automatic set_mem_tvar(input logic [19:0] b);
        for (int k = 0; k < 64; k++) begin
            wmem[k] = 20'h01000;
            for (int t = 0; t < 4; t++) hmem[t][k] = 20'(20'h01000 * (t + 1));
        end
        bias_m = b;
    endtask

    task automatic start_run(input logic [10:0] tl);
        @(negedge clk);
        start  = 1'b1;
        t_last = tl;
        @(posedge clk);
        #1;
        start  = 1'b0;
        t_last = 11'h7FF;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_valid(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_valid) begin
                to = 1'b0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic accept_result();
        o_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int cyc;
    bit to;
    int mce_seen;
    int val_seen;
    bit found;

    initial begin
        //               w_all     ix  w_ixv     h_all     ix  h_ixv     bias      exp
        vecs[0] = '{20'h01000, -1, 20'h0,    20'h10000, -1, 20'h0,    20'h08000, 20'h48000};
        vecs[1] = '{20'h00000,  0, 20'h00001, 20'h12345, 0, 20'h08000, 20'h00000, 20'h00001};
        vecs[2] = '{20'hF0000, -1, 20'h0,    20'h10000, -1, 20'h0,    20'hF0000, 20'h80000};
        vecs[3] = '{20'h10000, -1, 20'h0,    20'h10000, -1, 20'h0,    20'h10000, 20'h7FFFF};
        vecs[4] = '{20'h00000,  0, 20'h00001, 20'h00000, 0, 20'hF8000, 20'h00003, 20'h00003};
        vecs[5] = '{20'h00000,  0, 20'h00001, 20'h00000, 0, 20'h18000, 20'h00000, 20'h00002};
        vecs[6] = '{20'h00000, 37, 20'h00100, 20'h00100, 37, 20'h30000, 20'h00000, 20'h00300};
        vecs[7] = '{20'h00000, 63, 20'h00200, 20'h00100, 63, 20'h20000, 20'h00001, 20'h00401};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, mce, maddr, msel, o_valid, y_out, done}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Single-timestep vectors.
        for (int i = 0; i < 8; i++) begin
            set_mem(vecs[i]);
            o_ready = 1'b1;
            start_run(11'd0);
            wait_valid(cyc, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_latency_le_134", i), cyc <= 134, 1);
            check($sformatf("v%0d_y", i), y_out, vecs[i].exp_y);
            accept_result();
            @(negedge clk);
            check($sformatf("v%0d_done", i), {done, o_valid}, 2'b10);
            @(negedge clk);
            check($sformatf("v%0d_done_clear", i), {done, busy}, 2'b00);
        end

        // Three timesteps, first result stalled for 10 cycles.
        set_mem_tvar(20'h00010);
        o_ready = 1'b0;
        start_run(11'd2);
        wait_valid(cyc, to);
        check("stall_timeout", to, 0);
        check("stall_y0", y_out, 20'h04010);
        mce_seen = 0;
        val_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (y_out != 20'h04010) check("stall_y_hold", y_out, 20'h04010);
            if (mce) mce_seen++;
            if (o_valid) val_seen++;
        end
        check("stall_no_reads", mce_seen, 0);
        check("stall_valid_held", val_seen, 10);
        check("stall_y_after", y_out, 20'h04010);
        accept_result();
        wait_valid(cyc, to);
        check("stall_t1_timeout", to, 0);
        check("stall_y1", y_out, 20'h08010);
        check("stall_t1_no_done", done, 0);
        accept_result();
        wait_valid(cyc, to);
        check("stall_t2_timeout", to, 0);
        check("stall_y2", y_out, 20'h0C010);
        accept_result();
        @(negedge clk);
        check("stall_done", {done, o_valid}, 2'b10);
        check("rdh_addr_errs", addr_err, 0);

        // Reset during RDH of timestep 1, then a fresh run.
        set_mem(vecs[3]);
        o_ready = 1'b1;
        start_run(11'd2);
        wait_valid(cyc, to);
        check("rst_t0_timeout", to, 0);
        check("rst_t0_y", y_out, 20'h7FFFF);
        accept_result();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mce && msel == 3'b101 && maddr == {11'd1, 6'd10}) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reached_t1", found, 1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_outputs", {busy, mce, maddr, msel, o_valid, y_out, done}, 0);
        mce_seen = 0;
        val_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mce) mce_seen++;
            if (o_valid || done) val_seen++;
        end
        check("rst_no_reads", mce_seen, 0);
        check("rst_no_output", val_seen, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mce || o_valid || busy) val_seen++;
        end
        check("post_rst_idle", val_seen, 0);
        set_mem_tvar(20'h00020);
        start_run(11'd0);
        wait_valid(cyc, to);
        check("fresh_timeout", to, 0);
        check("fresh_latency_le_134", cyc <= 134, 1);
        check("fresh_y", y_out, 20'h04020);
        accept_result();
        @(negedge clk);
        check("fresh_done", {done, o_valid}, 2'b10);
        check("fresh_addr_errs", addr_err, 0);
        check("valid_done_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
